// File: rtl/mem_in_pkg.sv
// Shared constants and types for the accelerator input-data SRAM.
package mem_in_pkg;

   localparam int DATA_W = 8;
   localparam int ADDR_W = 15;
   localparam int DEPTH  = 2 ** ADDR_W;

   typedef logic [ADDR_W-1:0] addr_t;
   typedef logic [DATA_W-1:0] data_t;

endpackage

// File: rtl/mem_in_sram_if.sv
// SRAM macro pin bundle: active-low chip/write enables, address, data in/out.
interface mem_in_sram_if
   import mem_in_pkg::*;
();

   logic  CEN;
   logic  WEN;
   addr_t A;
   data_t D;
   data_t Q;

   modport master (
      output CEN,
      output WEN,
      output A,
      output D,
      input  Q
   );

   modport slave (
      input  CEN,
      input  WEN,
      input  A,
      input  D,
      output Q
   );

endinterface

// File: rtl/mem_in_array.sv
// Raw storage: synchronous write port and registered read port.
// The read register has a synchronous clear so the owner can force it to 0.
module mem_in_array
   import mem_in_pkg::*;
(
   input  logic  clk,
   input  logic  we_i,
   input  addr_t waddr_i,
   input  data_t wdata_i,
   input  logic  re_i,
   input  logic  rd_clr_i,
   input  addr_t raddr_i,
   output data_t rdata_o
);

   data_t mem_q [DEPTH];
   data_t rdata_q;

   // Array update; contents are never cleared, not even by reset.
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   // Registered read data; clear wins over a read, otherwise it holds.
   always_ff @(posedge clk) begin
      if (rd_clr_i) begin
         rdata_q <= '0;
      end else if (re_i) begin
         rdata_q <= mem_q[raddr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_in_sram.sv
// Single-port 32K x 8 input-data SRAM for the accelerator.
// Decodes CEN/WEN, applies synchronous reset to Q, and flags unknown controls.
module mem_in_sram
   import mem_in_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   mem_in_sram_if.slave  bus
);

   logic  wr_en;
   logic  rd_en;
   data_t rdata;

   // Reset blocks any access in its cycle. An unknown CEN/WEN makes the
   // enables unknown, which an if() treats as false, so no location is touched.
   assign wr_en = !rst && !bus.CEN && !bus.WEN;
   assign rd_en = !rst && !bus.CEN &&  bus.WEN;

   mem_in_array u_array (
      .clk      (clk),
      .we_i     (wr_en),
      .waddr_i  (bus.A),
      .wdata_i  (bus.D),
      .re_i     (rd_en),
      .rd_clr_i (rst),
      .raddr_i  (bus.A),
      .rdata_o  (rdata)
   );

   assign bus.Q = rdata;

   // Control pins must be driven to a known level whenever reset is low.
   always_ff @(posedge clk) begin
      if (!rst) begin
         assert (!$isunknown({bus.CEN, bus.WEN}))
            else $error("mem_in_sram: CEN/WEN unknown while out of reset");
      end
   end

endmodule

// File: tb/tb_mem_in_sram.sv
// Scoreboard bench for mem_in_sram: driver updates an array model and queues
// expected read data; a monitor tracks the expected Q every cycle.
module tb_mem_in_sram;
   import mem_in_pkg::*;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   mem_in_sram_if bus ();

   mem_in_sram dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   data_t model [DEPTH];
   data_t exp_q [$];
   int    checks = 0;
   int    passes = 0;
   string phase  = "init";

   task automatic check(input string name, input data_t act, input data_t exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s/%s: Q=%h expected %h at %0t", phase, name, act, exp, $time);
   endtask

   // One access cycle, driven 1 time unit after the rising edge.
   task automatic cyc(input bit r, input bit cen, input bit wen, input int a, input int d);
      @(posedge clk);
      #1;
      rst     = r;
      bus.CEN = cen;
      bus.WEN = wen;
      bus.A   = addr_t'(a);
      bus.D   = data_t'(d);
      if (!r && !cen) begin
         if (!wen) model[a] = data_t'(d);
         else      exp_q.push_back(model[a]);
      end
   endtask

   // Monitor: decide what Q must be after each edge, compare on the falling edge.
   initial begin : monitor
      data_t exp_cur;
      bit    known;
      logic  r, c, w;
      known = 1'b0;
      exp_cur = '0;
      forever begin
         @(posedge clk);
         r = rst;
         c = bus.CEN;
         w = bus.WEN;
         if (r === 1'b1) begin
            exp_cur = '0;
            known   = 1'b1;
         end else if (c === 1'b0 && w === 1'b1) begin
            if (exp_q.size() == 0) begin
               checks++;
               $display("FAIL %s/read_no_expect: read seen with empty scoreboard at %0t", phase, $time);
               known = 1'b0;
            end else begin
               exp_cur = exp_q.pop_front();
               known   = !$isunknown(exp_cur);
            end
         end
         @(negedge clk);
         if (known) check("q", bus.Q, exp_cur);
      end
   end

   initial begin : stim
      int a0;
      rst     = 1'b1;
      bus.CEN = 1'b1;
      bus.WEN = 1'b1;
      bus.A   = '0;
      bus.D   = '0;

      phase = "reset";
      cyc(1, 0, 1, 0, 0);
      cyc(1, 0, 1, 0, 0);
      cyc(0, 0, 0, 0, 8'h5A);
      cyc(0, 0, 1, 0, 0);
      cyc(0, 1, 1, 0, 0);

      phase = "chip_disable";
      cyc(0, 0, 0, 100, 8'hAA);
      for (int i = 0; i < 3; i++) cyc(0, 1, 0, 100, 8'h55);
      cyc(0, 0, 1, 100, 0);
      cyc(0, 1, 1, 0, 0);

      phase = "turnaround";
      cyc(0, 0, 0, DEPTH-1, 8'h3C);
      cyc(0, 0, 1, DEPTH-1, 0);
      cyc(0, 1, 1, 0, 0);

      phase = "reset_collision";
      cyc(0, 0, 0, 7, 8'h11);
      cyc(1, 0, 0, 7, 8'hFF);
      cyc(0, 0, 1, 7, 0);
      cyc(1, 0, 1, 7, 0);
      cyc(0, 0, 1, 7, 0);

      phase = "alternating";
      cyc(0, 0, 0, 0, $urandom_range(255));
      cyc(0, 0, 0, 1, $urandom_range(255));
      for (int i = 0; i < 40; i++) begin
         a0 = int'($urandom_range(1));
         if (i % 2 == 0) cyc(0, 0, 0, a0, $urandom_range(255));
         else            cyc(0, 0, 1, a0, 0);
      end

      phase = "sweep_write";
      for (int i = 0; i < DEPTH; i++) cyc(0, 0, 0, i, (i * 7 + 3) & 8'hFF);
      phase = "sweep_read";
      for (int i = 0; i < DEPTH; i++) cyc(0, 0, 1, i, 0);

      phase = "random";
      for (int i = 0; i < 3000; i++) begin
         cyc(($urandom_range(49) == 0), ($urandom_range(3) == 0), $urandom_range(1),
             $urandom_range(DEPTH-1), $urandom_range(255));
      end

      phase = "drain";
      cyc(0, 1, 1, 0, 0);
      cyc(0, 1, 1, 0, 0);
      @(posedge clk);
      @(negedge clk);
      #1;
      checks++;
      if (exp_q.size() == 0) passes++;
      else $display("FAIL drain/scoreboard_empty: %0d reads pending, expected 0", exp_q.size());

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
